// File: rtl/wir_access_ctrl.sv
`default_nettype none
// =============================================================================
// wir_access_ctrl : loads an instruction into the 1500 WIR (capture/shift/update)
// Revision: 1.0
// =============================================================================
module wir_access_ctrl #(
  parameter int WIR_LEN = 3
) (
  input  logic               WRCK,
  input  logic               WRSTN,
  input  logic               start,
  input  logic [WIR_LEN-1:0] opcode,
  output logic               busy,
  output logic               done,
  output logic [WIR_LEN-1:0] rd_data,
  output logic               select_wir,
  output logic               capture_wr,
  output logic               shift_wr,
  output logic               update_wr,
  output logic               wsi,
  input  logic               wso
);

  localparam int               CNT_W    = $clog2(WIR_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIR_LEN-1:0] sr_q, sr_d;
  logic [WIR_LEN-1:0] rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               select_q, select_d;
  logic               capture_q, capture_d;
  logic               shift_q, shift_d;
  logic               update_q, update_d;
  logic               wsi_q, wsi_d;

  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      select_q  <= 1'b0;
      capture_q <= 1'b0;
      shift_q   <= 1'b0;
      update_q  <= 1'b0;
      wsi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      select_q  <= select_d;
      capture_q <= capture_d;
      shift_q   <= shift_d;
      update_q  <= update_d;
      wsi_q     <= wsi_d;
    end
  end

  // Output strobes are a registered decode of the state, so each strobe
  // appears one cycle after its state is entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: state_d = SHIFT;
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = UPDATE;
        end
      end
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The data path follows the shift_wr strobe actually seen by the WIR.
    if (state_q == IDLE && start) begin
      sr_d = opcode;
    end else if (shift_q) begin
      sr_d = {wso, sr_q[WIR_LEN-1:1]};
    end

    if (state_q == DONE) begin
      rd_data_d = sr_q;
    end

    busy_d    = (state_q != IDLE);
    done_d    = (state_q == DONE);
    capture_d = (state_q == CAPTURE);
    shift_d   = (state_q == SHIFT);
    update_d  = (state_q == UPDATE);
    select_d  = capture_d | shift_d | update_d;
    wsi_d     = shift_d & sr_d[0];
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;
  assign select_wir = select_q;
  assign capture_wr = capture_q;
  assign shift_wr   = shift_q;
  assign update_wr  = update_q;
  assign wsi        = wsi_q;

endmodule
`default_nettype wire

// File: tb/tb_wir_access_ctrl.sv
`default_nettype none
// =============================================================================
// tb_wir_access_ctrl : WIR_LEN=3 and WIR_LEN=8 instances against a timeline model
// Revision: 1.0
// =============================================================================
module tb_wir_access_ctrl;

  logic       WRCK, WRSTN, start;
  logic [2:0] opcode3;
  logic [7:0] opcode8;
  logic       wso3, wso8;
  logic       busy3, done3, sel3, cap3, sh3, upd3, wsi3;
  logic [2:0] rd3;
  logic       busy8, done8, sel8, cap8, sh8, upd8, wsi8;
  logic [7:0] rd8;

  int n_assert = 0;
  int n_fail   = 0;

  // age = cycles since the accepting edge, -1 when idle
  int          age   [2];
  logic [15:0] op_m  [2];
  logic [15:0] acc_m [2];
  logic [15:0] rd_m  [2];
  logic [2:0]  wso_pat;
  bit          rand_wso;

  assign wso8 = wsi8;

  wir_access_ctrl #(.WIR_LEN(3)) u_dut3 (
    .WRCK(WRCK), .WRSTN(WRSTN), .start(start), .opcode(opcode3),
    .busy(busy3), .done(done3), .rd_data(rd3), .select_wir(sel3),
    .capture_wr(cap3), .shift_wr(sh3), .update_wr(upd3), .wsi(wsi3), .wso(wso3)
  );

  wir_access_ctrl #(.WIR_LEN(8)) u_dut8 (
    .WRCK(WRCK), .WRSTN(WRSTN), .start(start), .opcode(opcode8),
    .busy(busy8), .done(done8), .rd_data(rd8), .select_wir(sel8),
    .capture_wr(cap8), .shift_wr(sh8), .update_wr(upd8), .wsi(wsi8), .wso(wso8)
  );

  initial WRCK = 1'b0;
  always #5 WRCK = ~WRCK;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wl(input int i);
    return (i == 0) ? 3 : 8;
  endfunction

  function automatic logic exp_wsi(input int i);
    int a;
    a = age[i];
    if (a >= 2 && a <= wl(i) + 1) return op_m[i][a-2];
    return 1'b0;
  endfunction

  task automatic check_inst(input int i, input logic b, input logic d, input logic s,
                            input logic c, input logic sh, input logic u,
                            input logic wi, input logic [15:0] rd);
    int a, w;
    a = age[i];
    w = wl(i);
    check_eq($sformatf("busy_w%0d", w),   16'(b),  16'(a >= 1 && a <= w + 3));
    check_eq($sformatf("done_w%0d", w),   16'(d),  16'(a == w + 3));
    check_eq($sformatf("select_w%0d", w), 16'(s),  16'(a >= 1 && a <= w + 2));
    check_eq($sformatf("capture_w%0d", w),16'(c),  16'(a == 1));
    check_eq($sformatf("shift_w%0d", w),  16'(sh), 16'(a >= 2 && a <= w + 1));
    check_eq($sformatf("update_w%0d", w), 16'(u),  16'(a == w + 2));
    check_eq($sformatf("wsi_w%0d", w),    16'(wi), 16'(exp_wsi(i)));
    check_eq($sformatf("rd_data_w%0d", w), rd, rd_m[i]);
  endtask

  task automatic check_all();
    check_inst(0, busy3, done3, sel3, cap3, sh3, upd3, wsi3, 16'(rd3));
    check_inst(1, busy8, done8, sel8, cap8, sh8, upd8, wsi8, 16'(rd8));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      age[i]   = -1;
      op_m[i]  = '0;
      acc_m[i] = '0;
      rd_m[i]  = '0;
    end
  endtask

  // Advances the model across one rising edge using the inputs presented there.
  task automatic model_edge();
    int   a, w;
    logic wb;
    if (!WRSTN) return;
    for (int i = 0; i < 2; i++) begin
      a  = age[i];
      w  = wl(i);
      wb = (i == 0) ? wso3 : exp_wsi(i);
      if (a >= 2 && a <= w + 1) acc_m[i][a-2] = wb;
      if (a == w + 2) rd_m[i] = acc_m[i];
      if (a == -1 || a == w + 3) begin
        if (start) begin
          age[i]  = 0;
          op_m[i] = (i == 0) ? 16'(opcode3) : 16'(opcode8);
        end else begin
          age[i] = -1;
        end
      end else begin
        age[i] = a + 1;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic [2:0] o3, input logic [7:0] o8);
    @(negedge WRCK);
    check_all();
    start   = s;
    opcode3 = o3;
    opcode8 = o8;
    if (!rand_wso && age[0] >= 2 && age[0] <= 4) wso3 = wso_pat[age[0]-2];
    else wso3 = 1'($urandom);
    @(posedge WRCK);
    model_edge();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 3'($urandom), 8'($urandom));
  endtask

  task automatic reset_mid();
    @(negedge WRCK);
    check_all();
    WRSTN = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge WRCK);
    @(negedge WRCK);
    check_all();
    WRSTN = 1'b1;
    start = 1'b0;
    @(posedge WRCK);
    model_edge();
  endtask

  initial begin
    WRSTN    = 1'b1;
    start    = 1'b0;
    opcode3  = '0;
    opcode8  = '0;
    wso3     = 1'b0;
    wso_pat  = 3'b000;
    rand_wso = 1'b0;
    model_reset();
    #2 WRSTN = 1'b0;
    @(negedge WRCK);
    check_all();
    WRSTN = 1'b1;
    @(posedge WRCK);
    model_edge();

    // Basic load with wso tied low; the 8-bit instance loops back A5.
    cycle(1'b1, 3'b101, 8'hA5);
    idle_cycles(12);

    // Readback of wso = 1,1,0.
    wso_pat = 3'b011;
    cycle(1'b1, 3'($urandom), 8'($urandom));
    idle_cycles(12);

    // start held high: back-to-back transactions with fresh opcodes.
    for (int k = 0; k < 20; k++) cycle(1'b1, 3'($urandom), 8'($urandom));
    idle_cycles(12);

    // start pulsed mid-shift with a different opcode is ignored.
    cycle(1'b1, 3'b110, 8'h3C);
    cycle(1'b0, 3'b000, 8'h00);
    cycle(1'b0, 3'b000, 8'h00);
    cycle(1'b1, 3'b001, 8'hC3);
    idle_cycles(12);

    // Reset during the second shift cycle, then a clean transaction.
    cycle(1'b1, 3'b111, 8'h5A);
    idle_cycles(3);
    reset_mid();
    cycle(1'b1, 3'b010, 8'h96);
    idle_cycles(12);

    // Randomized traffic.
    rand_wso = 1'b1;
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 3) == 0), 3'($urandom), 8'($urandom));
    @(negedge WRCK);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wir_access_ctrl.md
WIR_ACCESS_CTRL -- requirements
Module: wir_access_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIR_LEN, default 3, Wrapper Instruction Register length in bits (legal range 2..16).
REQ-002 The block SHALL have these ports, clock and reset first:
- WRCK  input  1  wrapper clock; all state changes on its rising edge.
- WRSTN  input  1  asynchronous, active-low reset.
- start  input  1  host request to load a new instruction.
- opcode  input  WIR_LEN  instruction to shift in, LSB first.
- busy  output  1  a transaction is in progress.
- done  output  1  one-cycle pulse when a transaction ends.
- rd_data  output  WIR_LEN  bits captured from the WIR during the shift.
- select_wir  output  1  selects the WIR as the active register.
- capture_wr  output  1  WIR capture strobe (wir_capture).
- shift_wr  output  1  WIR shift enable (wir_shift).
- update_wr  output  1  WIR update strobe (wir_update).
- wsi  output  1  serial data to the WIR serial input.
- wso  input  1  serial data from the WIR serial output (wir_so).

Function
REQ-003 All outputs SHALL be registered and change only on a WRCK rising edge, except while WRSTN is low.
REQ-004 The state machine SHALL have five states: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
REQ-005 In IDLE, start=1 at a rising edge SHALL latch opcode into a WIR_LEN-bit shift register, clear the bit counter and move to CAPTURE.
REQ-006 start SHALL be ignored in every state other than IDLE; opcode SHALL be sampled only on the accepting edge.
REQ-007 CAPTURE SHALL last exactly one cycle with capture_wr=1 and select_wir=1, then move to SHIFT.
REQ-008 SHIFT SHALL last exactly WIR_LEN cycles with shift_wr=1 and select_wir=1.
REQ-009 wsi SHALL equal shift register bit 0 throughout each SHIFT cycle.
REQ-010 At each rising edge that ends a SHIFT cycle, the shift register SHALL shift right by one, with wso entering at bit WIR_LEN-1, and the counter SHALL increment.
REQ-011 The counter SHALL be ceil(log2(WIR_LEN+1)) bits wide. The block SHALL leave SHIFT when the counter reaches WIR_LEN-1 at a shift edge, with no wrap-around.
REQ-012 UPDATE SHALL last exactly one cycle with update_wr=1, select_wir=1 and shift_wr=0, then move to DONE.
REQ-013 In DONE, done SHALL be 1 for exactly one cycle and rd_data SHALL hold the full shift register contents.
REQ-014 After DONE the block SHALL return to IDLE; a new start SHALL be accepted from the edge that ends the DONE cycle onward.
REQ-015 rd_data SHALL hold its value until the next DONE.
REQ-016 busy SHALL be 1 in CAPTURE, SHIFT, UPDATE and DONE, and 0 in IDLE.
REQ-017 capture_wr, shift_wr and update_wr SHALL be mutually exclusive; at most one is high in any cycle.
REQ-018 wsi SHALL be 0 outside SHIFT.
REQ-019 Latency: with start sampled at edge 0, done SHALL be high in cycle WIR_LEN+3, i.e. the cycle after edge WIR_LEN+3.

Reset
REQ-020 WRSTN=0 SHALL immediately force state IDLE and set busy, done, select_wir, capture_wr, shift_wr, update_wr and wsi to 0, the counter to 0, and rd_data and the shift register to all zeros.
REQ-021 Reset asserted mid-transaction SHALL abort it with no update_wr pulse and no done pulse.
REQ-022 The block SHALL start operating at the first rising edge after WRSTN is released.

Verification
REQ-023 Basic load, WIR_LEN=3: opcode=3'b101, start for one cycle, wso tied to 0 -> capture_wr for 1 cycle, wsi sequence 1,0,1 over 3 shift_wr cycles, update_wr for 1 cycle, done in cycle 6, rd_data=3'b000.
REQ-024 Capture readback: wso driven 1,1,0 on successive shift cycles -> rd_data=3'b011 at done.
REQ-025 start held high continuously -> back-to-back transactions, each 6 busy cycles long, separated by exactly one IDLE cycle, with opcode re-sampled each time.
REQ-026 Pulse start during SHIFT with a different opcode -> ignored; the current wsi sequence is unchanged and no extra transaction occurs.
REQ-027 Drop WRSTN during the second SHIFT cycle -> all outputs 0 at once, no update_wr or done; after release, a new start completes normally.
REQ-028 WIR_LEN=8, opcode=8'hA5, wso looped back from wsi -> 8 shift cycles, done in cycle 11, rd_data=8'hA5.
